// File: rtl/vx_warp_issue_sched.sv
// Round-robin issue scheduler: picks one eligible warp per cycle into a registered
// elastic issue slot, and keeps issue-stage performance counters.
module vx_warp_issue_sched #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_EX      = 5,
    parameter int EX_BITS     = 3,
    parameter int PERF_W      = 44
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WARPS-1:0]             req_valid,
    input  logic [NUM_WARPS-1:0]             req_hazard,
    input  logic [NUM_WARPS*EX_BITS-1:0]     req_ex_type,
    input  logic [NUM_WARPS*NUM_THREADS-1:0] req_tmask,
    output logic [NUM_WARPS-1:0]             req_ready,
    input  logic [NUM_EX-1:0]                unit_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(NUM_WARPS)-1:0]     out_wid,
    output logic [EX_BITS-1:0]               out_ex_type,
    output logic [NUM_THREADS-1:0]           out_tmask,
    output logic [PERF_W-1:0]                perf_issued,
    output logic [PERF_W-1:0]                perf_threads,
    output logic [PERF_W-1:0]                perf_scb_stalls,
    output logic [PERF_W-1:0]                perf_unit_stalls
);
    localparam int WID_W   = $clog2(NUM_WARPS);
    localparam int EX_SPAN = 2 ** EX_BITS;

    function automatic logic [PERF_W-1:0] popcount(input logic [NUM_THREADS-1:0] m);
        logic [PERF_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_THREADS; i++) s = s + PERF_W'(m[i]);
        return s;
    endfunction

    logic [WID_W-1:0]       rr_ptr;
    logic [EX_SPAN-1:0]     unit_ready_ext;
    logic [NUM_WARPS-1:0]   eligible;
    logic                   any_eligible;
    logic [WID_W-1:0]       grant;
    logic [EX_BITS-1:0]     grant_ex;
    logic [NUM_THREADS-1:0] grant_tmask;
    logic                   load_en;

    // Out-of-range unit codes land on zero bits of the extended ready vector.
    assign unit_ready_ext = EX_SPAN'(unit_ready);

    always_comb begin
        logic [EX_BITS-1:0] ex;
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            ex = req_ex_type[w*EX_BITS +: EX_BITS];
            eligible[w] = req_valid[w] & ~req_hazard[w]
                        & (32'(ex) < NUM_EX) & unit_ready_ext[ex];
        end
    end

    assign any_eligible = |eligible;

    always_comb begin
        int  idx;
        logic found;
        grant       = '0;
        grant_ex    = '0;
        grant_tmask = '0;
        found       = 1'b0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_WARPS;
            if (!found && eligible[idx]) begin
                found       = 1'b1;
                grant       = WID_W'(idx);
                grant_ex    = req_ex_type[idx*EX_BITS +: EX_BITS];
                grant_tmask = req_tmask[idx*NUM_THREADS +: NUM_THREADS];
            end
        end
    end

    assign load_en   = ~reset & (~out_valid | out_ready) & any_eligible;
    assign req_ready = load_en ? (NUM_WARPS'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid        <= 1'b0;
            out_wid          <= '0;
            out_ex_type      <= '0;
            out_tmask        <= '0;
            rr_ptr           <= '0;
            perf_issued      <= '0;
            perf_threads     <= '0;
            perf_scb_stalls  <= '0;
            perf_unit_stalls <= '0;
        end else begin
            if (load_en) begin
                out_valid    <= 1'b1;
                out_wid      <= grant;
                out_ex_type  <= grant_ex;
                out_tmask    <= grant_tmask;
                rr_ptr       <= (grant == WID_W'(NUM_WARPS-1)) ? '0 : grant + 1'b1;
                perf_issued  <= perf_issued + 1'b1;
                perf_threads <= perf_threads + popcount(grant_tmask);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (|(req_valid & req_hazard) && !any_eligible)
                perf_scb_stalls <= perf_scb_stalls + 1'b1;
            if (out_valid && !out_ready)
                perf_unit_stalls <= perf_unit_stalls + 1'b1;
        end
    end
endmodule

// File: tb/tb_vx_warp_issue_sched.sv
// Randomized and directed bench for vx_warp_issue_sched against a cycle-level reference model.
module tb_vx_warp_issue_sched;
    localparam int NW = 4, NT = 4, NE = 5, EB = 3, PW = 44;

    logic          clk = 1'b0;
    logic          reset;
    logic [NW-1:0] req_valid, req_hazard, req_ready, req_ready2;
    logic [NW*EB-1:0] req_ex_type;
    logic [NW*NT-1:0] req_tmask;
    logic [NE-1:0] unit_ready;
    logic          out_valid, out_ready, out_valid2;
    logic [1:0]    out_wid, out_wid2;
    logic [EB-1:0] out_ex_type, out_ex_type2;
    logic [NT-1:0] out_tmask, out_tmask2;
    logic [PW-1:0] perf_issued, perf_threads, perf_scb_stalls, perf_unit_stalls;
    logic [2:0]    p2_issued, p2_threads, p2_scb, p2_unit;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_valid;
    int            m_wid, m_ex, m_tmask, m_rr;
    logic [PW-1:0] m_issued, m_threads, m_scb, m_unit;

    always #5 clk = ~clk;

    vx_warp_issue_sched #(.NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_EX(NE), .EX_BITS(EB), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_hazard(req_hazard),
        .req_ex_type(req_ex_type), .req_tmask(req_tmask), .req_ready(req_ready),
        .unit_ready(unit_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_wid(out_wid), .out_ex_type(out_ex_type), .out_tmask(out_tmask),
        .perf_issued(perf_issued), .perf_threads(perf_threads),
        .perf_scb_stalls(perf_scb_stalls), .perf_unit_stalls(perf_unit_stalls));

    // Narrow-counter instance: exercises counter wrap within a short run.
    vx_warp_issue_sched #(.NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_EX(NE), .EX_BITS(EB), .PERF_W(3)) dut_w (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_hazard(req_hazard),
        .req_ex_type(req_ex_type), .req_tmask(req_tmask), .req_ready(req_ready2),
        .unit_ready(unit_ready), .out_valid(out_valid2), .out_ready(out_ready),
        .out_wid(out_wid2), .out_ex_type(out_ex_type2), .out_tmask(out_tmask2),
        .perf_issued(p2_issued), .perf_threads(p2_threads),
        .perf_scb_stalls(p2_scb), .perf_unit_stalls(p2_unit));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit elig(input int w);
        int ex;
        ex = int'(req_ex_type[w*EB +: EB]);
        return req_valid[w] && !req_hazard[w] && ex < NE && unit_ready[ex];
    endfunction

    // One clock: check combinational strobe, advance model, check registered state.
    task automatic step();
        int  g;
        bit  load;
        logic [NW-1:0] exp_rdy;
        #2;
        g = -1;
        for (int i = 0; i < NW; i++)
            if (g < 0 && elig((m_rr + i) % NW)) g = (m_rr + i) % NW;
        load    = !reset && (!m_valid || out_ready) && g >= 0;
        exp_rdy = load ? NW'(1 << g) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_wid = 0; m_ex = 0; m_tmask = 0; m_rr = 0;
            m_issued = 0; m_threads = 0; m_scb = 0; m_unit = 0;
        end else begin
            if (m_valid && !out_ready) m_unit++;
            if ((req_valid & req_hazard) != 0 && g < 0) m_scb++;
            if (load) begin
                m_valid = 1;
                m_wid   = g;
                m_ex    = int'(req_ex_type[g*EB +: EB]);
                m_tmask = int'(req_tmask[g*NT +: NT]);
                m_issued++;
                m_threads += PW'($countones(req_tmask[g*NT +: NT]));
                m_rr = (g + 1) % NW;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_wid", 64'(out_wid), 64'(m_wid));
        check("out_ex_type", 64'(out_ex_type), 64'(m_ex));
        check("out_tmask", 64'(out_tmask), 64'(m_tmask));
        check("perf_issued", 64'(perf_issued), 64'(m_issued));
        check("perf_threads", 64'(perf_threads), 64'(m_threads));
        check("perf_scb_stalls", 64'(perf_scb_stalls), 64'(m_scb));
        check("perf_unit_stalls", 64'(perf_unit_stalls), 64'(m_unit));
        check("perf_issued_narrow", 64'(p2_issued), 64'(m_issued[2:0]));
    endtask

    task automatic set_idle();
        req_valid = '0; req_hazard = '0; req_ex_type = '0;
        req_tmask = '0; unit_ready = '1; out_ready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        req_valid = '1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        m_valid = 0; m_wid = 0; m_ex = 0; m_tmask = 0; m_rr = 0;
        m_issued = 0; m_threads = 0; m_scb = 0; m_unit = 0;
        do_reset();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_issued", 64'(perf_issued), 64'd0);

        // Round robin over all four warps
        set_idle();
        req_valid = 4'b1111;
        req_tmask = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_seq", 64'(out_wid), 64'(i % 4));
        end
        check("rr_issued5", 64'(perf_issued), 64'd5);

        // Hazard skip
        do_reset();
        req_valid = 4'b0110; req_hazard = 4'b0010;
        step();
        check("hz_grant2", 64'(out_wid), 64'd2);
        check("hz_scb0", 64'(perf_scb_stalls), 64'd0);
        req_hazard = 4'b0110;
        step(); step();
        check("hz_scb2", 64'(perf_scb_stalls), 64'd2);
        check("hz_drain", 64'(out_valid), 64'd0);

        // Backpressure
        do_reset();
        req_valid = 4'b0010;
        step();
        req_valid = 4'b1000; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_wid", 64'(out_wid), 64'd1);
        end
        check("bp_unit3", 64'(perf_unit_stalls), 64'd3);
        out_ready = 1'b1;
        step();
        check("bp_wid3", 64'(out_wid), 64'd3);

        // Unit gating and illegal unit code
        do_reset();
        req_valid = 4'b0011; req_ex_type = 12'o0001; unit_ready = 5'b11101;
        step();
        check("ug_grant1", 64'(out_wid), 64'd1);
        req_valid = 4'b0001; req_ex_type = 12'o0007; unit_ready = '1;
        for (int i = 0; i < 3; i++) step();
        check("ug_never", 64'(out_valid), 64'd0);
        check("ug_issued", 64'(perf_issued), 64'd1);

        // Thread counts
        do_reset();
        req_valid = 4'b0001; req_tmask = 16'h000B;
        step();
        check("thr_plus3", 64'(perf_threads), 64'd3);
        req_tmask = 16'h0000;
        step();
        check("thr_plus0", 64'(perf_threads), 64'd3);

        // Counter wrap on the narrow instance
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) step();
        check("wrap_narrow", 64'(p2_issued), 64'd0);
        check("wrap_wide", 64'(perf_issued), 64'd8);

        // Random traffic with occasional mid-stream reset
        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(0, 59) == 0);
            req_valid  = NW'($urandom);
            req_hazard = NW'($urandom) & NW'($urandom);
            for (int w = 0; w < NW; w++)
                req_ex_type[w*EB +: EB] = ($urandom_range(0, 9) == 0) ?
                    EB'($urandom_range(5, 7)) : EB'($urandom_range(0, 4));
            req_tmask  = (NW*NT)'($urandom);
            unit_ready = NE'($urandom) | NE'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
